// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I fetch/decode engine: opcodes, format and
// FSM encodings, and sign-extension helpers used by the immediate generator.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_SB  = 3'd3,
        FMT_U   = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_UNK = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic [31:0] sext13(input logic [12:0] v);
        return {{19{v[12]}}, v};
    endfunction

    function automatic logic [31:0] sext21(input logic [20:0] v);
        return {{11{v[20]}}, v};
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and immediate builder for one RV32I word.
// Unrecognised opcodes report UNK with a zero immediate and flag illegal.
module rv_imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output fmt_t        fmt,
    output logic [31:0] imm,
    output logic        illegal
);

    // Opcode decode and per-format immediate assembly
    always_comb begin
        fmt     = FMT_UNK;
        imm     = 32'd0;
        illegal = 1'b0;
        case (instr[6:0])
            OP_R: begin
                fmt = FMT_R;
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                fmt = FMT_I;
                imm = sext12(instr[31:20]);
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = sext12({instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                fmt = FMT_SB;
                imm = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = {instr[31:12], 12'd0};
            end
            OP_JAL: begin
                fmt = FMT_UJ;
                imm = sext21({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
            end
            default: begin
                fmt     = FMT_UNK;
                imm     = 32'd0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_fetch_decode.sv
// Sequential fetch-and-decode engine: walks instruction memory from BASE_ADDR,
// one non-overlapped fetch per instruction, and presents decoded fields on valid/ready.
module rv_fetch_decode
    import rv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h28),
    parameter int                N_INSTR   = 11,
    parameter int                MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [2:0]        fmt,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [31:0]       imm,
    output logic              illegal,
    output logic              done
);

    localparam logic [2:0]  LAT_LAST = 3'(MEM_LAT - 1);
    localparam logic [15:0] N_LAST   = 16'(N_INSTR);

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [15:0]         count_r;
    logic [15:0]         count_inc_s;
    logic [2:0]          lat_r;
    logic [31:0]         instr_r;
    fmt_t                fmt_r;
    logic [31:0]         imm_r;
    logic                illegal_r;
    logic                mem_read_r;
    logic                out_valid_r;
    logic                done_r;
    logic                hs_s;
    logic                lat_last_s;
    logic                last_s;
    logic                start_run_s;
    logic                capture_s;
    fmt_t                dec_fmt_s;
    logic [31:0]         dec_imm_s;
    logic                dec_illegal_s;

    // Decode is done on the incoming word so every presented field comes from a register.
    rv_imm_gen u_imm_gen (
        .instr   (mem_rdata),
        .fmt     (dec_fmt_s),
        .imm     (dec_imm_s),
        .illegal (dec_illegal_s)
    );

    assign hs_s        = out_valid_r && out_ready;
    assign lat_last_s  = (lat_r == LAT_LAST);
    assign count_inc_s = count_r + 16'd1;
    assign last_s      = (count_inc_s == N_LAST) || illegal_r;
    assign capture_s   = (state_r == ST_FETCH) && lat_last_s;

    // Next-state logic for the fetch/present sequencer
    always_comb begin
        state_s     = state_r;
        start_run_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s     = ST_FETCH;
                    start_run_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                if (lat_last_s) begin
                    state_s = ST_PRESENT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_PRESENT: begin
                if (hs_s) begin
                    state_s = last_s ? ST_DONE : ST_FETCH;
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, strobes and run bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mem_read_r  <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            pc_r        <= BASE_ADDR;
            count_r     <= 16'd0;
            lat_r       <= 3'd0;
        end else begin
            state_r     <= state_s;
            mem_read_r  <= (state_s == ST_FETCH);
            out_valid_r <= (state_s == ST_PRESENT);
            done_r      <= (state_s == ST_DONE);
            if (start_run_s) begin
                pc_r    <= BASE_ADDR;
                count_r <= 16'd0;
            end else if (hs_s) begin
                pc_r    <= pc_r + ADDR_W'(4);
                count_r <= count_inc_s;
            end else begin
                pc_r    <= pc_r;
                count_r <= count_r;
            end
            // lat_r rests at zero outside FETCH so each fetch starts counting afresh
            if ((state_r == ST_FETCH) && !lat_last_s) begin
                lat_r <= lat_r + 3'd1;
            end else begin
                lat_r <= 3'd0;
            end
        end
    end

    // Instruction and decode capture on the final memory-latency cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r   <= 32'd0;
            fmt_r     <= FMT_R;
            imm_r     <= 32'd0;
            illegal_r <= 1'b0;
        end else if (capture_s) begin
            instr_r   <= mem_rdata;
            fmt_r     <= dec_fmt_s;
            imm_r     <= dec_imm_s;
            illegal_r <= dec_illegal_s;
        end else begin
            instr_r   <= instr_r;
            fmt_r     <= fmt_r;
            imm_r     <= imm_r;
            illegal_r <= illegal_r;
        end
    end

    assign mem_addr  = pc_r;
    assign mem_read  = mem_read_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign pc        = pc_r;
    assign instr     = instr_r;
    assign fmt       = fmt_r;
    assign imm       = imm_r;
    assign illegal   = illegal_r;
    assign opcode    = instr_r[6:0];
    assign rd        = instr_r[11:7];
    assign funct3    = instr_r[14:12];
    assign rs1       = instr_r[19:15];
    assign rs2       = instr_r[24:20];
    assign funct7    = instr_r[31:25];

endmodule

// File: tb/tb_rv_fetch_decode.sv
// Scoreboard bench for rv_fetch_decode: instance 0 (N_INSTR=4, MEM_LAT=1) and
// instance 1 (N_INSTR=11, MEM_LAT=3) share one instruction memory image.
module tb_rv_fetch_decode;
    import rv_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [1:0]       start;
    logic [1:0]       out_ready;
    logic [1:0]       mem_read;
    logic [1:0]       out_valid;
    logic [1:0]       illegal;
    logic [1:0]       done;
    logic [1:0][31:0] pc;
    logic [1:0][31:0] instr;
    logic [1:0][31:0] imm;
    logic [1:0][2:0]  fmt;
    logic [1:0][6:0]  opcode;
    logic [1:0][4:0]  rd;
    logic [1:0][2:0]  funct3;
    logic [1:0][4:0]  rs1;
    logic [1:0][4:0]  rs2;
    logic [1:0][6:0]  funct7;

    logic [31:0] tb_mem [0:31];
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int NI  = (g == 0) ? 4 : 11;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [2:0]  rd_cnt;

        // Memory returns the word only once mem_read has been held LAT cycles
        always @(posedge clk or posedge reset) begin
            if (reset) rd_cnt <= 3'd0;
            else if (mem_read[g]) rd_cnt <= rd_cnt + 3'd1;
            else rd_cnt <= 3'd0;
        end
        assign rdata = (mem_read[g] && rd_cnt == 3'(LAT - 1)) ? tb_mem[addr[6:2]] : 32'hDEAD_BEEF;

        rv_fetch_decode #(.ADDR_W(32), .BASE_ADDR(32'h28), .N_INSTR(NI), .MEM_LAT(LAT)) dut (
            .clk(clk), .reset(reset), .start(start[g]),
            .mem_addr(addr), .mem_read(mem_read[g]), .mem_rdata(rdata),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .pc(pc[g]), .instr(instr[g]), .fmt(fmt[g]), .opcode(opcode[g]),
            .rd(rd[g]), .funct3(funct3[g]), .rs1(rs1[g]), .rs2(rs2[g]),
            .funct7(funct7[g]), .imm(imm[g]), .illegal(illegal[g]), .done(done[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input int g, input exp_t e);
        string p;
        p = $sformatf("u%0d@%h", g, e.pc);
        chk({p, " pc"},      pc[g], e.pc);
        chk({p, " instr"},   instr[g], e.word);
        chk({p, " fmt"},     32'(fmt[g]), 32'(e.fmt));
        chk({p, " imm"},     imm[g], e.imm);
        chk({p, " illegal"}, 32'(illegal[g]), 32'(e.ill));
        chk({p, " opcode"},  32'(opcode[g]), 32'(e.word[6:0]));
        chk({p, " rd"},      32'(rd[g]), 32'(e.word[11:7]));
        chk({p, " funct3"},  32'(funct3[g]), 32'(e.word[14:12]));
        chk({p, " rs1"},     32'(rs1[g]), 32'(e.word[19:15]));
        chk({p, " rs2"},     32'(rs2[g]), 32'(e.word[24:20]));
        chk({p, " funct7"},  32'(funct7[g]), 32'(e.word[31:25]));
    endtask

    // Monitor: every handshake pops and checks the oldest expected response
    always @(negedge clk) begin
        if (!reset && out_valid[0] && out_ready[0]) begin
            if (q0.size() == 0) chk("u0 unexpected output", instr[0], 32'hFFFF_0000);
            else check_out(0, q0.pop_front());
        end
        if (!reset && out_valid[1] && out_ready[1]) begin
            if (q1.size() == 0) chk("u1 unexpected output", instr[1], 32'hFFFF_0000);
            else check_out(1, q1.pop_front());
        end
    end

    task automatic push(input int g, input logic [31:0] p, input logic [31:0] w,
                        input fmt_t f, input logic [31:0] i, input logic ill);
        exp_t e;
        e.pc = p; e.word = w; e.fmt = f; e.imm = i; e.ill = ill;
        if (g == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic load4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        tb_mem[10] = a; tb_mem[11] = b; tb_mem[12] = c; tb_mem[13] = d;
    endtask

    task automatic pulse_start(input int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!done[g] && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("u%0d done within budget", g), 32'(done[g]), 32'd1);
    endtask

    task automatic reset_checks(input int g);
        string p;
        p = $sformatf("u%0d reset", g);
        chk({p, " pc"},        pc[g], 32'h28);
        chk({p, " mem_read"},  32'(mem_read[g]), 32'd0);
        chk({p, " out_valid"}, 32'(out_valid[g]), 32'd0);
        chk({p, " done"},      32'(done[g]), 32'd0);
        chk({p, " instr"},     instr[g], 32'd0);
        chk({p, " fmt"},       32'(fmt[g]), 32'd0);
        chk({p, " imm"},       imm[g], 32'd0);
        chk({p, " illegal"},   32'(illegal[g]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] mr;
        logic [5:0] ov;
        logic       rd_seen;
        int         n;

        reset = 1'b1; start = 2'b00; out_ready = 2'b11;
        for (int i = 0; i < 32; i++) tb_mem[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) reset_checks(g);
        @(posedge clk); #1 reset = 1'b0;

        // Format sweep R / I / SB / UJ
        load4(32'h007302B3, 32'h00832283, 32'hFE208CE3, 32'h010000EF);
        push(0, 32'h28, 32'h007302B3, FMT_R,  32'h00000000, 1'b0);
        push(0, 32'h2C, 32'h00832283, FMT_I,  32'h00000008, 1'b0);
        push(0, 32'h30, 32'hFE208CE3, FMT_SB, 32'hFFFFFFF8, 1'b0);
        push(0, 32'h34, 32'h010000EF, FMT_UJ, 32'h00000010, 1'b0);
        pulse_start(0);
        wait_done(0, 40);
        chk("sweep end pc", pc[0], 32'h38);

        // U / S / negative I / AUIPC with backpressure on the first word
        load4(32'h123452B7, 32'hFE532E23, 32'hFFF00013, 32'h00001017);
        push(0, 32'h28, 32'h123452B7, FMT_U, 32'h12345000, 1'b0);
        push(0, 32'h2C, 32'hFE532E23, FMT_S, 32'hFFFFFFFC, 1'b0);
        push(0, 32'h30, 32'hFFF00013, FMT_I, 32'hFFFFFFFF, 1'b0);
        push(0, 32'h34, 32'h00001017, FMT_U, 32'h00001000, 1'b0);
        out_ready[0] = 1'b0;
        pulse_start(0);
        n = 0;
        while (!out_valid[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp valid reached", 32'(out_valid[0]), 32'd1);
        start[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid[0]), 32'd1);
            chk("bp instr",     instr[0], 32'h123452B7);
            chk("bp pc",        pc[0], 32'h28);
            chk("bp mem_read",  32'(mem_read[0]), 32'd0);
            @(posedge clk); #1 start[0] = 1'b0;
        end
        out_ready[0] = 1'b1;
        wait_done(0, 40);
        chk("bp end pc", pc[0], 32'h38);

        // Latency MEM_LAT=3 and illegal-opcode halt
        load4(32'h007302B3, 32'hFFFFFFFF, 32'h00832283, 32'h00832283);
        push(1, 32'h28, 32'h007302B3, FMT_R,   32'h00000000, 1'b0);
        push(1, 32'h2C, 32'hFFFFFFFF, FMT_UNK, 32'h00000000, 1'b1);
        @(posedge clk); #1 start[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mr[c] = mem_read[1];
            ov[c] = out_valid[1];
            @(posedge clk); #1 start[1] = 1'b0;
        end
        chk("lat mem_read cycles 0-5", 32'(mr), 32'(6'b101110));
        chk("lat out_valid cycles 0-5", 32'(ov), 32'(6'b010000));
        wait_done(1, 30);
        chk("illegal halt pc", pc[1], 32'h30);
        chk("illegal halt flag", 32'(illegal[1]), 32'd1);
        rd_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rd_seen = rd_seen | mem_read[1];
        end
        chk("no fetch after illegal", 32'(rd_seen), 32'd0);

        // Reset during the second FETCH cycle, then a clean rerun
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        @(posedge clk); #1;
        chk("mid-fetch mem_read", 32'(mem_read[1]), 32'd1);
        #1 reset = 1'b1;
        #1;
        reset_checks(1);
        @(posedge clk); #1 reset = 1'b0;
        push(1, 32'h28, 32'h007302B3, FMT_R,   32'h00000000, 1'b0);
        push(1, 32'h2C, 32'hFFFFFFFF, FMT_UNK, 32'h00000000, 1'b1);
        pulse_start(1);
        wait_done(1, 30);
        chk("rerun end pc", pc[1], 32'h30);

        repeat (2) @(posedge clk);
        chk("u0 scoreboard drained", 32'(q0.size()), 32'd0);
        chk("u1 scoreboard drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_fetch_decode.md
Name: rv_fetch_decode

Overview:
- Sequential instruction fetch-and-decode engine for the lab RISC-V datapath.
- Walks instruction memory from a programmable base address and reads one word per instruction.
- Splits each word into RV32I fields, classifies its format, builds the sign-extended immediate and presents the result on a valid/ready output.
- Successor to the fixed-count, display-only field splitter: adds a parametrised memory latency, count and address width; U-type support; immediate generation; backpressure; illegal-opcode halt.

Parameters:
- ADDR_W, 32, width of the instruction address / PC.
- BASE_ADDR, 32'h28, first fetch address after start.
- N_INSTR, 11, number of instructions to deliver before done (1..2^16-1).
- MEM_LAT, 1, cycles from mem_read assertion to valid mem_rdata (1..7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from BASE_ADDR.
- mem_addr  out  ADDR_W  word address to instruction memory.
- mem_read  out  1  read strobe.
- mem_rdata  in  32  instruction word.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  consumer accepts the instruction.
- pc  out  ADDR_W  address of the presented instruction.
- instr  out  32  raw instruction word.
- fmt  out  3  0=R 1=I 2=S 3=SB 4=U 5=UJ 7=UNK.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- imm  out  32  sign-extended immediate (0 for R and UNK).
- illegal  out  1  presented opcode unrecognised.
- done  out  1  run finished.

Behaviour:
- Reset (async): FSM=IDLE; pc=BASE_ADDR; count=0; instr=0; mem_read=0; out_valid=0; done=0; illegal=0; every field output is 0.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE/DONE + start: pc=BASE_ADDR, count=0, done=0, go to FETCH. start is ignored in FETCH/PRESENT.
- FETCH:
  - mem_read=1 and mem_addr=pc for exactly MEM_LAT cycles.
  - On the last of those cycles, mem_rdata is registered into instr and the FSM moves to PRESENT.
- PRESENT:
  - out_valid=1; all field outputs are driven from the registered instr.
  - Fields and outputs stay stable while out_ready=0.
  - Latency: start in cycle 0 gives first out_valid in cycle MEM_LAT+1.
- Handshake (out_valid && out_ready):
  - count+1, pc+4 (wraps modulo 2^ADDR_W).
  - If count+1==N_INSTR or illegal: go to DONE.
  - Otherwise go to FETCH the next cycle. No overlapping fetch, so throughput is one instruction per MEM_LAT+1 cycles at best.
- Format decode from opcode:
  - 0x33 -> R.
  - 0x03, 0x13, 0x67 -> I.
  - 0x23 -> S.
  - 0x63 -> SB.
  - 0x37, 0x17 -> U.
  - 0x6F -> UJ.
  - Anything else -> UNK with illegal=1. The word is still presented, and the run halts after its handshake.
- Immediate construction:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - SB: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - UJ: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- DONE: done=1, out_valid=0, mem_read=0; pc holds the next unfetched address; remains until start or reset.
- Reset mid-FETCH or mid-PRESENT: immediate return to reset values; the partial fetch is discarded.
- out_ready asserted outside PRESENT has no effect.

Decomposition:
- Package rv_pkg holds:
  - Opcode constants: OP_R, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - Format enum fmt_t.
  - State enum for the FSM.
- One combinational sub-module, rv_imm_gen (instr in -> fmt, imm, illegal out). The FSM, PC/count registers and memory sequencing stay in the top module.

Test Plan:
- Format sweep: memory at 0x28.. holds 0x007302B3, 0x00832283, 0xFE208CE3, 0x010000EF, N_INSTR=4, out_ready=1. Required responses:
  - 0x007302B3: fmt=R, rd=5, rs1=6, rs2=7, funct3=0, funct7=0, imm=0, pc=0x28.
  - 0x00832283: fmt=I, rd=5, rs1=6, funct3=2, imm=0x00000008.
  - 0xFE208CE3: fmt=SB, rs1=1, rs2=2, imm=0xFFFFFFF8.
  - 0x010000EF: fmt=UJ, rd=1, imm=0x00000010.
  - After the fourth handshake, done=1 and pc=0x38.
- U-type and S-type: 0x123452B7 gives fmt=U, rd=5, imm=0x12345000. 0xFE532E23 gives fmt=S, rs1=6, rs2=5, imm=0xFFFFFFFC.
- Backpressure: hold out_ready=0 for 3 cycles in PRESENT. out_valid, instr and pc must stay constant, mem_read=0, and count must not advance.
- Illegal opcode: second word is 0xFFFFFFFF with N_INSTR=11. It is presented with fmt=7 and illegal=1; after its handshake done=1 and no third fetch occurs.
- Latency: MEM_LAT=3, start at cycle 0. mem_read is high in cycles 1-3 and out_valid first rises in cycle 4.
- Reset mid-operation: assert reset in cycle 2 of FETCH. All outputs go to reset values before the next edge; a later start refetches from 0x28.
